fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fft_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// fft_sequencer: frame controller wrapped around a streaming FFT core.
// It latches the transform size and direction, writes the core setup,
// counts the load and unload beats, and reports completion or rejection.
// Optional build macro FFT_SEQ_TIMEOUT_EN adds a no-progress watchdog.
// The watchdog covers LOAD, WAIT and UNLOAD. Without the macro the block
// waits indefinitely for the core.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for i_Go; checks the requested size
// SETUP   | one-cycle write of size/direction into the core
// LOAD    | core pulls N input samples (i_FftRfd beats)
// WAIT    | core transforming; waits for i_FftDone
// UNLOAD  | core pushes N output samples (i_FftDv beats)
// DONE    | one-cycle completion pulse

module fft_sequencer #(
    parameter int MIN_LOG2       = 3,
    parameter int MAX_LOG2       = 10,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    input  logic                i_Go,
    input  logic [4:0]          i_Log2N,
    input  logic                i_Inverse,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Error,
    output logic [4:0]          o_FftNfft,
    output logic                o_FftFwdInv,
    output logic                o_FftSetupWe,
    output logic                o_FftStart,
    output logic                o_FftUnload,
    input  logic                i_FftRfd,
    input  logic                i_FftDv,
    input  logic                i_FftDone,
    input  logic [MAX_LOG2-1:0] i_FftXnIndex,
    input  logic [MAX_LOG2-1:0] i_FftXkIndex,
    output logic [MAX_LOG2-1:0] o_InAddr,
    output logic                o_OutWe,
    output logic [MAX_LOG2-1:0] o_OutAddr
);

    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_setup  = 3'd1;
    localparam logic [2:0] st_load   = 3'd2;
    localparam logic [2:0] st_wait   = 3'd3;
    localparam logic [2:0] st_unload = 3'd4;
    localparam logic [2:0] st_done   = 3'd5;

    // One extra bit so the count can reach N = 2**MAX_LOG2 without wrapping.
    localparam int              beat_w     = MAX_LOG2 + 1;
    localparam logic [beat_w-1:0] beat_one = 1;
    localparam logic [4:0]      min_log2_c = 5'(MIN_LOG2);
    localparam logic [4:0]      max_log2_c = 5'(MAX_LOG2);

    logic [2:0]        state;
    logic [beat_w-1:0] beat_cnt;
    logic [beat_w-1:0] beat_last;
    logic [4:0]        nfft;
    logic              fwd_inv;
    logic              err_pulse;
    logic              was_setup;
    logic              size_ok;
    logic              load_beat;
    logic              unload_beat;
    logic              core_done;
    logic              timeout_hit;
    logic              run;

    assign run         = !i_Reset;
    assign size_ok     = (i_Log2N >= min_log2_c) && (i_Log2N <= max_log2_c);
    assign beat_last   = (beat_one << nfft) - beat_one;
    assign load_beat   = (state == st_load)   && i_FftRfd;
    assign unload_beat = (state == st_unload) && i_FftDv;
    assign core_done   = (state == st_wait)   && i_FftDone;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int to_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [to_w-1:0] to_last = to_w'(TIMEOUT_CYCLES - 1);

    logic [to_w-1:0] to_cnt;
    logic            active;
    logic            progress;

    assign active      = (state == st_load) || (state == st_wait) || (state == st_unload);
    assign progress    = load_beat || unload_beat || core_done;
    assign timeout_hit = active && !progress && (to_cnt == to_last);

    // No-progress counter; any beat, core done or leaving the active states clears it.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            to_cnt <= '0;
        end else if (!active || progress || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Frame state machine, beat counter and latched configuration.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= st_idle;
            beat_cnt  <= '0;
            nfft      <= '0;
            fwd_inv   <= 1'b0;
            err_pulse <= 1'b0;
            was_setup <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            was_setup <= (state == st_setup);
            case (state)
                st_idle: begin
                    if (i_Go) begin
                        if (size_ok) begin
                            nfft    <= i_Log2N;
                            fwd_inv <= i_Inverse;
                            state   <= st_setup;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end
                end
                st_setup: begin
                    beat_cnt <= '0;
                    state    <= st_load;
                end
                st_load: begin
                    if (load_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == beat_last) begin
                            state <= st_wait;
                        end
                    end
                end
                st_wait: begin
                    if (core_done) begin
                        beat_cnt <= '0;
                        state    <= st_unload;
                    end
                end
                st_unload: begin
                    if (unload_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == beat_last) begin
                            state <= st_done;
                        end
                    end
                end
                st_done: begin
                    state <= st_idle;
                end
                default: begin
                    state <= st_idle;
                end
            endcase
            if (timeout_hit) begin
                err_pulse <= 1'b1;
                state     <= st_idle;
            end
        end
    end

    // Outputs are forced low while reset is asserted, including the pass-throughs.
    always_comb begin
        o_Busy       = run && (state != st_idle);
        o_Done       = run && (state == st_done);
        o_Error      = run && err_pulse;
        o_FftNfft    = run ? nfft : 5'd0;
        o_FftFwdInv  = run && fwd_inv;
        o_FftSetupWe = run && (state == st_setup);
        o_FftStart   = run && (state == st_load) && was_setup;
        o_FftUnload  = run && core_done;
        o_InAddr     = run ? i_FftXnIndex : '0;
        o_OutWe      = run && unload_beat;
        o_OutAddr    = (run && (state == st_unload)) ? i_FftXkIndex : '0;
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: driver tasks push the expected output
// events; a negedge monitor pops and compares whenever the DUT pulses one.

module tb_fft_sequencer;

    localparam int max_log2 = 10;

    localparam int k_setup  = 1;
    localparam int k_start  = 2;
    localparam int k_unload = 3;
    localparam int k_outwe  = 4;
    localparam int k_done   = 5;
    localparam int k_error  = 6;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                go = 1'b0;
    logic [4:0]          log2n_in = '0;
    logic                inverse = 1'b0;
    logic                busy, done, error, fwd_inv_out, setup_we, start, unload, out_we;
    logic [4:0]          nfft_out;
    logic                rfd = 1'b0, dv = 1'b0, core_done = 1'b0;
    logic [max_log2-1:0] xn = '0, xk = '0;
    logic [max_log2-1:0] in_addr, out_addr;

    int  tests = 0;
    int  fails = 0;
    ev_t sb[$];

    fft_sequencer #(
        .MIN_LOG2(3),
        .MAX_LOG2(max_log2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Go(go),
        .i_Log2N(log2n_in),
        .i_Inverse(inverse),
        .o_Busy(busy),
        .o_Done(done),
        .o_Error(error),
        .o_FftNfft(nfft_out),
        .o_FftFwdInv(fwd_inv_out),
        .o_FftSetupWe(setup_we),
        .o_FftStart(start),
        .o_FftUnload(unload),
        .i_FftRfd(rfd),
        .i_FftDv(dv),
        .i_FftDone(core_done),
        .i_FftXnIndex(xn),
        .i_FftXkIndex(xk),
        .o_InAddr(in_addr),
        .o_OutWe(out_we),
        .o_OutAddr(out_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int xk_of(input int i, input int n);
        return (i * 5 + 3) % n;
    endfunction

    // Monitor: one DUT event per cycle at most, checked against the queue head.
    task automatic monitor_sample();
        int  n_act;
        int  kind;
        int  data;
        ev_t e;
        n_act = int'(setup_we) + int'(start) + int'(unload) + int'(out_we) + int'(done) + int'(error);
        kind = 0;
        data = 0;
        if (n_act > 1) begin
            check("sb_one_event_per_cycle", n_act, 1);
        end else if (n_act == 1) begin
            if (setup_we)    begin kind = k_setup;  data = int'(fwd_inv_out) * 32 + int'(nfft_out); end
            else if (start)  begin kind = k_start;  data = int'(nfft_out); end
            else if (unload) begin kind = k_unload; data = 0; end
            else if (out_we) begin kind = k_outwe;  data = int'(out_addr); end
            else if (done)   begin kind = k_done;   data = int'(nfft_out); end
            else             begin kind = k_error;  data = int'(nfft_out); end
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got event kind %0d data %0d, expected none", kind, data);
            end else begin
                e = sb.pop_front();
                check("sb_kind", kind, e.kind);
                check("sb_data", data, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) monitor_sample();
    end

    task automatic run_frame(input int log2n, input bit inv, input bit gap, input bit go_hold);
        int n;
        int beats;
        int k;
        n = 1 << log2n;
        push(k_setup, int'(inv) * 32 + log2n);
        push(k_start, log2n);
        push(k_unload, 0);
        for (int i = 0; i < n; i++) push(k_outwe, xk_of(i, n));
        push(k_done, log2n);

        go = 1'b1;
        log2n_in = 5'(log2n);
        inverse = inv;
        step();
        if (!go_hold) begin
            go = 1'b0;
            log2n_in = 5'd0;
            inverse = !inv;
        end
        step();
        beats = 0;
        k = 0;
        while (beats < n) begin
            rfd = !(gap && (k % 3 == 2));
            xn = max_log2'(beats);
            core_done = (beats == n - 1) && rfd;
            if (k < 3) begin
                #1;
                check("in_addr_passthrough", int'(in_addr), beats);
            end
            if (rfd) beats++;
            k++;
            step();
        end
        rfd = 1'b0;
        core_done = 1'b0;
        // Stray strobes in WAIT must not load, unload or write.
        rfd = 1'b1;
        dv = 1'b1;
        xk = 10'd77;
        step();
        step();
        rfd = 1'b0;
        dv = 1'b0;
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        beats = 0;
        k = 0;
        while (beats < n) begin
            dv = !(gap && (k % 3 == 2));
            xk = max_log2'(xk_of(beats, n));
            if (dv) beats++;
            k++;
            step();
        end
        dv = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        check("done_after_last_dv", int'(done), 1);
        step();
        core_done = 1'b0;
        go = 1'b0;
        @(negedge clk);
        check("idle_after_done", int'(busy), 0);
    endtask

    task automatic bad_req(input int log2n, input int prev_nfft);
        push(k_error, prev_nfft);
        go = 1'b1;
        log2n_in = 5'(log2n);
        step();
        go = 1'b0;
        @(negedge clk);
        check("bad_size_busy", int'(busy), 0);
        check("bad_size_nfft_kept", int'(nfft_out), prev_nfft);
        step();
        @(negedge clk);
        check("bad_size_err_one_cycle", int'(error), 0);
        step();
    endtask

    function automatic int all_outs();
        return int'(busy) + int'(done) + int'(error) + int'(nfft_out) + int'(fwd_inv_out)
             + int'(setup_we) + int'(start) + int'(unload) + int'(in_addr)
             + int'(out_we) + int'(out_addr);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        xn = 10'd5;
        xk = 10'd9;
        repeat (3) step();
        check("reset_outputs_zero", all_outs(), 0);
        rst = 1'b0;
        xn = '0;
        xk = '0;
        step();
        @(negedge clk);
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_nfft", int'(nfft_out), 0);

        run_frame(3, 1'b0, 1'b0, 1'b0);
        run_frame(10, 1'b1, 1'b1, 1'b0);
        check("fwd_inv_held", int'(fwd_inv_out), 1);
        bad_req(2, 10);
        bad_req(11, 10);

        // Abandon a frame with reset after 5 load beats.
        push(k_setup, 4);
        push(k_start, 4);
        go = 1'b1;
        log2n_in = 5'd4;
        inverse = 1'b0;
        step();
        go = 1'b0;
        step();
        rfd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            xn = max_log2'(i);
            step();
        end
        rst = 1'b1;
        dv = 1'b1;
        core_done = 1'b1;
        xn = 10'd7;
        xk = 10'd3;
        #1;
        check("mid_frame_reset_outputs_zero", all_outs(), 0);
        step();
        rst = 1'b0;
        rfd = 1'b0;
        dv = 1'b0;
        core_done = 1'b0;
        xn = '0;
        xk = '0;
        @(negedge clk);
        check("after_reset_busy", int'(busy), 0);
        check("after_reset_nfft", int'(nfft_out), 0);
        step();
        run_frame(4, 1'b0, 1'b0, 1'b0);

        run_frame(5, 1'b1, 1'b0, 1'b1);
        step();
        @(negedge clk);
        check("go_hold_single_frame", int'(busy), 0);

`ifdef FFT_SEQ_TIMEOUT_EN
        push(k_setup, 3);
        push(k_start, 3);
        push(k_error, 3);
        go = 1'b1;
        log2n_in = 5'd3;
        inverse = 1'b0;
        step();
        go = 1'b0;
        step();
        rfd = 1'b1;
        repeat (8) step();
        rfd = 1'b0;
        repeat (15) step();
        @(negedge clk);
        check("timeout_not_early", int'(error), 0);
        check("timeout_still_busy", int'(busy), 1);
        step();
        @(negedge clk);
        check("timeout_error", int'(error), 1);
        check("timeout_idle", int'(busy), 0);
        step();
`endif

        repeat (3) step();
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
